fft_result_streamer: RTL and testbench
======================================

Name: fft_result_streamer

Overview:
- Downstream stage of the 4-point FFT engine top level.
- Captures all four complex bins (8-bit signed real/imag) on a single result strobe into a local frame buffer.
- Streams the frame out as 8 full-precision bytes over a valid/ready byte interface, so the host is not limited to upper-nibble readout.
- Provides frame markers, a busy status and a sticky overrun flag for results that arrive while a frame is still streaming.

Parameters:
- SCALE_SHIFT, 0, arithmetic right shift (0..3) applied to every captured value before buffering; sign-extended, truncating.
- BITREV_ORDER, 0, 0: bins sent in order 0,1,2,3; 1: bins sent in order 0,2,1,3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  global enable; when low, all state is frozen
- capture  in  1  one-cycle strobe; in*_real/imag are valid this cycle
- in0_real, in0_imag, in1_real, in1_imag, in2_real, in2_imag, in3_real, in3_imag  in  8 each  signed FFT bins
- out_data  out  8  current byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the byte
- out_first  out  1  high with byte 0 of a frame
- out_last  out  1  high with byte 7 of a frame
- busy  out  1  a frame is buffered or streaming
- overrun  out  1  sticky flag: a capture was dropped
- clear_overrun  in  1  clears overrun

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; buffer, byte index, out_data, out_valid, out_first, out_last, busy and overrun all 0. Reset mid-frame aborts the frame immediately; the partial frame is never resumed.
- ena low:
  - No state, register or flag changes.
  - out_valid is forced to 0, so no handshake can occur.
  - capture and clear_overrun are ignored.
- FSM has two states, IDLE and SEND.
- IDLE:
  - busy = 0, out_valid = 0.
  - capture=1 with ena=1: latch the eight scaled inputs, set byte index to 0, go to SEND.
  - out_valid rises the next cycle, carrying byte 0 (latency 1).
- SEND:
  - busy = 1; out_valid = ena.
  - Byte index b is 0..7. Bin slot s = b>>1; b even sends real, b odd sends imag.
  - Bin number equals s when BITREV_ORDER=0, and bitrev2(s) when BITREV_ORDER=1.
  - out_first = (b==0); out_last = (b==7); both are qualified by out_valid.
- Handshake: a byte transfers when out_valid && out_ready.
  - On transfer, b increments.
  - On a transfer at b==7, go to IDLE.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_ready may be high before out_valid; a transfer requires both.
- Capture while in SEND:
  - Not at the final transfer: the capture is dropped, overrun is set, and the buffer is unchanged.
  - In the same cycle as the b==7 transfer: the capture is accepted. The buffer reloads, b=0, and the state stays SEND. The next frame starts the following cycle with no idle bubble and no overrun.
- overrun:
  - Set takes priority over clear_overrun in the same cycle.
  - Once set, it stays set until clear_overrun=1 with ena=1.
- Scaling:
  - value = in >>> SCALE_SHIFT, applied at capture.
  - The result always fits in 8 bits; there is no saturation.
- out_data is registered, with no combinational path from the inputs. out_ready → out_valid has no combinational path.

Test Plan:
- Reset, then capture with bins (10,-3),(20,4),(-128,127),(0,-1) and out_ready held 1 → next cycle starts 8 consecutive bytes 0A,FD,14,04,80,7F,00,FF. out_first is on byte 1 of the 8 (value 0A); out_last is on FF; busy falls after FF.
- Same frame with out_ready toggling 1,0,0,1,… → out_data is held stable while stalled, all 8 bytes arrive exactly once and in order, and no overrun is flagged.
- capture asserted while the 3rd byte is pending → overrun=1 and the frame continues unchanged. clear_overrun → overrun=0. capture coinciding with the last-byte transfer → second frame starts next cycle and overrun stays 0.
- SCALE_SHIFT=2, BITREV_ORDER=1, bins (-128,100),(8,-8),(64,-64),(1,2) → bytes E0,19,10,F0,02,FE,00,00.
- ena driven low mid-frame for 5 cycles → out_valid=0 with no progress; on ena=1 the stream resumes at the same byte. rst_n pulsed low mid-frame → all outputs are 0 immediately and the next capture starts at byte 0.

Source files
------------

// File: rtl/fft_result_streamer.sv
// ============================================================================
// Module   : fft_result_streamer
// Purpose  : Buffers one 4-bin complex FFT result and streams it as 8 bytes
//            over a valid/ready interface with frame markers and overrun flag.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft_result_streamer #(
    parameter int SCALE_SHIFT  = 0,
    parameter int BITREV_ORDER = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       capture,
    input  logic [7:0] in0_real,
    input  logic [7:0] in0_imag,
    input  logic [7:0] in1_real,
    input  logic [7:0] in1_imag,
    input  logic [7:0] in2_real,
    input  logic [7:0] in2_imag,
    input  logic [7:0] in3_real,
    input  logic [7:0] in3_imag,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_first,
    output logic       out_last,
    output logic       busy,
    output logic       overrun,
    input  logic       clear_overrun
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [7:0] raw_re    [4];
    logic signed [7:0] raw_im    [4];
    logic signed [7:0] scaled_re [4];
    logic signed [7:0] scaled_im [4];
    logic        [7:0] frame_in  [8];
    logic        [7:0] frame_buf [8];
    logic        [2:0] byte_idx;

    logic xfer;
    logic load;
    logic advance;
    logic finish;
    logic drop;

    assign raw_re[0] = in0_real;
    assign raw_im[0] = in0_imag;
    assign raw_re[1] = in1_real;
    assign raw_im[1] = in1_imag;
    assign raw_re[2] = in2_real;
    assign raw_im[2] = in2_imag;
    assign raw_re[3] = in3_real;
    assign raw_im[3] = in3_imag;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_scale
            assign scaled_re[i] = raw_re[i] >>> SCALE_SHIFT;
            assign scaled_im[i] = raw_im[i] >>> SCALE_SHIFT;
        end
    endgenerate

    // The buffer is kept in transmit order, so bin reordering costs only wiring.
    generate
        for (genvar b = 0; b < 8; b++) begin : g_order
            localparam int SLOT = b / 2;
            localparam int BIN  = (BITREV_ORDER != 0) ? ((SLOT % 2) * 2 + SLOT / 2) : SLOT;
            if (b % 2 == 0) begin : g_real
                assign frame_in[b] = scaled_re[BIN];
            end else begin : g_imag
                assign frame_in[b] = scaled_im[BIN];
            end
        end
    endgenerate

    assign busy      = (state == SEND);
    assign out_valid = busy && ena;
    assign out_first = out_valid && (byte_idx == 3'd0);
    assign out_last  = out_valid && (byte_idx == 3'd7);
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (ena && capture) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (byte_idx == 3'd7) begin
                        // A capture on the closing transfer chains the next frame.
                        if (capture) begin
                            load = 1'b1;
                        end else begin
                            finish     = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                if (ena && capture && !(xfer && byte_idx == 3'd7)) begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                frame_buf[i] <= 8'h00;
            end
            byte_idx <= 3'd0;
            out_data <= 8'h00;
            overrun  <= 1'b0;
        end else if (ena) begin
            if (load) begin
                for (int i = 0; i < 8; i++) begin
                    frame_buf[i] <= frame_in[i];
                end
                byte_idx <= 3'd0;
                out_data <= frame_in[0];
            end else if (advance) begin
                byte_idx <= byte_idx + 3'd1;
                out_data <= frame_buf[byte_idx + 3'd1];
            end else if (finish) begin
                byte_idx <= 3'd0;
                out_data <= 8'h00;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_result_streamer.sv
// ============================================================================
// Module   : tb_fft_result_streamer
// Purpose  : Directed bench for fft_result_streamer; two instances (default and
//            SCALE_SHIFT=2/BITREV_ORDER=1) checked against a frame-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena, capture, out_ready, clear_overrun;
    logic [7:0] re [4];
    logic [7:0] im [4];

    logic [7:0] a_data, b_data;
    logic a_valid, a_first, a_last, a_busy, a_ovr;
    logic b_valid, b_first, b_last, b_busy, b_ovr;

    fft_result_streamer #(.SCALE_SHIFT(0), .BITREV_ORDER(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .capture(capture),
        .in0_real(re[0]), .in0_imag(im[0]), .in1_real(re[1]), .in1_imag(im[1]),
        .in2_real(re[2]), .in2_imag(im[2]), .in3_real(re[3]), .in3_imag(im[3]),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .out_first(a_first), .out_last(a_last), .busy(a_busy),
        .overrun(a_ovr), .clear_overrun(clear_overrun)
    );

    fft_result_streamer #(.SCALE_SHIFT(2), .BITREV_ORDER(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .capture(capture),
        .in0_real(re[0]), .in0_imag(im[0]), .in1_real(re[1]), .in1_imag(im[1]),
        .in2_real(re[2]), .in2_imag(im[2]), .in3_real(re[3]), .in3_imag(im[3]),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .out_first(b_first), .out_last(b_last), .busy(b_busy),
        .overrun(b_ovr), .clear_overrun(clear_overrun)
    );

    int cmp_count  = 0;
    int fail_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: the frame a capture produces, and where the stream is.
    int   fa [8];
    int   fb [8];
    bit   m_send;
    int   m_idx;
    bit   m_ovr;
    logic m_xfer, m_final;

    assign m_xfer  = m_send && ena && out_ready;
    assign m_final = m_xfer && (m_idx == 7);

    function automatic int frame_byte(int b, int sh, int brev);
        int s   = b >> 1;
        int bin = (brev != 0) ? (((s & 1) << 1) | (s >> 1)) : s;
        int v   = (b & 1) ? int'($signed(im[bin])) : int'($signed(re[bin]));
        return (v >>> sh) & 255;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_send <= 1'b0;
            m_idx  <= 0;
            m_ovr  <= 1'b0;
        end else if (ena) begin
            if (capture && (!m_send || m_final)) begin
                for (int b = 0; b < 8; b++) begin
                    fa[b] <= frame_byte(b, 0, 0);
                    fb[b] <= frame_byte(b, 2, 1);
                end
                m_idx  <= 0;
                m_send <= 1'b1;
            end else if (m_xfer) begin
                if (m_idx == 7) m_send <= 1'b0;
                else            m_idx  <= m_idx + 1;
            end
            if (capture && m_send && !m_final) m_ovr <= 1'b1;
            else if (clear_overrun)            m_ovr <= 1'b0;
        end
    end

    typedef logic [9:0] ent_t;
    ent_t qa[$];
    ent_t qb[$];

    always @(negedge clk) begin
        logic ev;
        ev = m_send && ena;
        chk("a.valid", a_valid, ev);
        chk("a.first", a_first, ev && m_idx == 0);
        chk("a.last",  a_last,  ev && m_idx == 7);
        chk("a.busy",  a_busy,  m_send);
        chk("a.ovr",   a_ovr,   m_ovr);
        chk("b.valid", b_valid, ev);
        chk("b.first", b_first, ev && m_idx == 0);
        chk("b.last",  b_last,  ev && m_idx == 7);
        chk("b.busy",  b_busy,  m_send);
        chk("b.ovr",   b_ovr,   m_ovr);
        if (ev) begin
            chk("a.data", a_data, fa[m_idx]);
            chk("b.data", b_data, fb[m_idx]);
        end
        if (!rst_n) begin
            chk("a.data_rst", a_data, 0);
            chk("b.data_rst", b_data, 0);
        end
        if (a_valid && out_ready) qa.push_back({a_first, a_last, a_data});
        if (b_valid && out_ready) qb.push_back({b_first, b_last, b_data});
    end

    // Hand-computed frames
    logic [7:0] lit_f1_a [8] = '{8'h0A, 8'hFD, 8'h14, 8'h04, 8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [7:0] lit_f1_b [8] = '{8'h02, 8'hFF, 8'hE0, 8'h1F, 8'h05, 8'h01, 8'h00, 8'hFF};
    logic [7:0] lit_f2_a [8] = '{8'h80, 8'h64, 8'h08, 8'hF8, 8'h40, 8'hC0, 8'h01, 8'h02};
    logic [7:0] lit_f2_b [8] = '{8'hE0, 8'h19, 8'h10, 8'hF0, 8'h02, 8'hFE, 8'h00, 8'h00};

    task automatic check_log(input string name, input int which, input logic [7:0] exp [8], input int base);
        ent_t e;
        int   sz;
        sz = (which != 0) ? qb.size() : qa.size();
        if (sz < base + 8) begin
            chk({name, ".len"}, sz, base + 8);
        end else begin
            for (int i = 0; i < 8; i++) begin
                e = (which != 0) ? qb[base + i] : qa[base + i];
                chk({name, ".byte"},  e[7:0], exp[i]);
                chk({name, ".first"}, e[9],   i == 0);
                chk({name, ".last"},  e[8],   i == 7);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_f1();
        re = '{8'h0A, 8'h14, 8'h80, 8'h00};
        im = '{8'hFD, 8'h04, 8'h7F, 8'hFF};
    endtask

    task automatic load_f2();
        re = '{8'h80, 8'h08, 8'h40, 8'h01};
        im = '{8'h64, 8'hF8, 8'hC0, 8'h02};
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (a_busy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk({name, ".idle_timeout"}, 1, 0);
    endtask

    initial begin
        int n;
        logic [3:0] pat;
        rst_n = 1'b0; ena = 1'b1; capture = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
        re = '{8'h00, 8'h00, 8'h00, 8'h00};
        im = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) tick();
        chk("rst.valid", a_valid, 0);
        chk("rst.busy",  a_busy,  0);
        chk("rst.ovr",   a_ovr,   0);
        chk("rst.data",  a_data,  0);
        rst_n = 1'b1;
        tick();

        // Straight frame, consumer always ready
        load_f1();
        out_ready = 1'b1;
        pulse_capture();
        chk("t1.lat_valid", a_valid, 1);
        chk("t1.lat_data",  a_data,  8'h0A);
        wait_idle("t1");
        chk("t1.len", qa.size(), 8);
        check_log("t1.a", 0, lit_f1_a, 0);
        check_log("t1.b", 1, lit_f1_b, 0);
        qa.delete(); qb.delete();

        // Backpressure pattern 1,0,0,1
        pat = 4'b1001;
        pulse_capture();
        n = 0;
        while (a_busy && n < 100) begin
            out_ready = pat[3 - (n % 4)];
            tick();
            n++;
        end
        if (n >= 100) chk("t2.idle_timeout", 1, 0);
        out_ready = 1'b1;
        chk("t2.len", qa.size(), 8);
        check_log("t2.a", 0, lit_f1_a, 0);
        chk("t2.ovr", a_ovr, 0);
        qa.delete(); qb.delete();

        // Capture while byte 2 pending is dropped
        pulse_capture();
        tick();
        tick();
        load_f2();
        pulse_capture();
        chk("t3.ovr_set", a_ovr, 1);
        wait_idle("t3");
        check_log("t3.a", 0, lit_f1_a, 0);
        chk("t3.len", qa.size(), 8);
        qa.delete(); qb.delete();
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t3.ovr_clr", a_ovr, 0);

        // Capture on the closing transfer chains without a bubble
        load_f1();
        pulse_capture();
        n = 0;
        while (!a_last && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("t3b.last_timeout", 1, 0);
        load_f2();
        pulse_capture();
        chk("t3b.chain_valid", a_valid, 1);
        chk("t3b.chain_first", a_first, 1);
        wait_idle("t3b");
        chk("t3b.len", qa.size(), 16);
        check_log("t3b.a1", 0, lit_f1_a, 0);
        check_log("t3b.a2", 0, lit_f2_a, 8);
        check_log("t3b.b1", 1, lit_f1_b, 0);
        check_log("t3b.b2", 1, lit_f2_b, 8);
        chk("t3b.ovr", a_ovr, 0);
        qa.delete(); qb.delete();

        // ena low mid-frame freezes the stream
        load_f1();
        pulse_capture();
        tick();
        tick();
        ena = 1'b0;
        repeat (5) begin
            tick();
            chk("t4.frozen_valid", a_valid, 0);
        end
        ena = 1'b1;
        wait_idle("t4");
        chk("t4.len", qa.size(), 8);
        check_log("t4.a", 0, lit_f1_a, 0);

        // Asynchronous reset mid-frame aborts it
        pulse_capture();
        tick();
        tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.rst_valid", a_valid, 0);
        chk("t5.rst_busy",  a_busy,  0);
        chk("t5.rst_data",  a_data,  0);
        chk("t5.rst_last",  a_last,  0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        qa.delete(); qb.delete();
        load_f2();
        pulse_capture();
        wait_idle("t5");
        chk("t5.len", qa.size(), 8);
        check_log("t5.a", 0, lit_f2_a, 0);
        check_log("t5.b", 1, lit_f2_b, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

`default_nettype wire
